// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer
// Bit-serial add/subtract sequencer. Operands are accepted over a valid/ready
// handshake, streamed LSB first through an external 1-bit full-adder cell
// (one bit pair per clock, running carry held locally), and the assembled
// result plus Carry/Overflow/Zero flags is offered over a second handshake.
module serial_add_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             cell_a,
    output logic             cell_b,
    output logic             cell_cin,
    input  logic             cell_y,
    input  logic             cell_carry,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             res_valid,
    input  logic             res_ready
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    // Counter value on the edge that consumes the MSB pair.
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    // Counter value on the edge whose carry-out feeds the MSB.
    localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             carry_q,     carry_d;
    logic             cin_msb_q,   cin_msb_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [WIDTH-1:0] y_q,         y_d;
    logic             carry_out_q, carry_out_d;
    logic             ovf_q,       ovf_d;
    logic             zero_q,      zero_d;
    logic             res_valid_q, res_valid_d;

    // Result register after inserting this cycle's sum bit at the MSB end.
    logic [WIDTH-1:0] acc_shift_s;
    assign acc_shift_s = {cell_y, acc_q[WIDTH-1:1]};

    // State register and datapath flops, all asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CW{1'b0}};
            carry_q     <= 1'b0;
            cin_msb_q   <= 1'b0;
            a_sh_q      <= {WIDTH{1'b0}};
            b_sh_q      <= {WIDTH{1'b0}};
            acc_q       <= {WIDTH{1'b0}};
            y_q         <= {WIDTH{1'b0}};
            carry_out_q <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cin_msb_q   <= cin_msb_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            carry_out_q <= carry_out_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            res_valid_q <= res_valid_d;
        end
    end

    // Next-state and datapath update: load, shift one bit pair per cycle, finish.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cin_msb_d   = cin_msb_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        acc_d       = acc_q;
        y_d         = y_q;
        carry_out_d = carry_out_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        res_valid_d = res_valid_q;

        case (state_q)
            S_IDLE: begin
                res_valid_d = 1'b0;
                if (start_valid) begin
                    // Subtraction is A + ~B + 1: invert B here, seed carry with 1.
                    a_sh_d  = a;
                    b_sh_d  = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = {CW{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d   = acc_shift_s;
                carry_d = cell_carry;
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == CNT_MSB) begin
                    cin_msb_d = cell_carry;
                end else begin
                    cin_msb_d = cin_msb_q;
                end
                if (cnt_q == CNT_LAST) begin
                    // Overflow: carry into MSB differs from carry out of MSB.
                    state_d     = S_DONE;
                    y_d         = acc_shift_s;
                    carry_out_d = cell_carry;
                    ovf_d       = cin_msb_q ^ cell_carry;
                    zero_d      = (acc_shift_s == {WIDTH{1'b0}});
                    res_valid_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d     = S_IDLE;
                    res_valid_d = 1'b0;
                end else begin
                    state_d     = S_DONE;
                    res_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                res_valid_d = 1'b0;
            end
        endcase
    end

    // Cell drive: current bit pair and running carry while running, quiet otherwise.
    always_comb begin
        cell_a   = 1'b0;
        cell_b   = 1'b0;
        cell_cin = 1'b0;
        if (state_q == S_RUN) begin
            cell_a   = a_sh_q[0];
            cell_b   = b_sh_q[0];
            cell_cin = carry_q;
        end else begin
            cell_a   = 1'b0;
            cell_b   = 1'b0;
            cell_cin = 1'b0;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign y           = y_q;
    assign carry       = carry_out_q;
    assign overflow    = ovf_q;
    assign zero        = zero_q;
    assign res_valid   = res_valid_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed testbench for serial_add_sequencer (WIDTH=8) with a behavioural
// full-adder cell closing the loop.
module tb_serial_add_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic       cell_a;
    logic       cell_b;
    logic       cell_cin;
    logic       cell_y;
    logic       cell_carry;
    logic [7:0] y;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       res_valid;
    logic       res_ready;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    logic [7:0] cin_seq;

    serial_add_sequencer #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_ready(start_ready),
        .a(a), .b(b), .sub(sub),
        .cell_a(cell_a), .cell_b(cell_b), .cell_cin(cell_cin),
        .cell_y(cell_y), .cell_carry(cell_carry),
        .y(y), .carry(carry), .overflow(overflow), .zero(zero),
        .res_valid(res_valid), .res_ready(res_ready)
    );

    // Combinational full-adder cell.
    assign cell_y     = cell_a ^ cell_b ^ cell_cin;
    assign cell_carry = (cell_a & cell_b) | (cell_a & cell_cin) | (cell_b & cell_cin);

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] ey,
                                input logic ec, input logic ev, input logic ez);
        check_eq({tag, "_y"}, 32'(y), 32'(ey));
        check_eq({tag, "_cvz"}, 32'({carry, overflow, zero}), 32'({ec, ev, ez}));
    endtask

    // Entered at a negedge; returns at the negedge where res_valid is first seen.
    task automatic launch(input logic [7:0] ta, input logic [7:0] tbv, input logic ts);
        int n;
        n = 0;
        while (!start_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        check_eq("launch_ready", 32'(start_ready), 32'd1);
        a = ta; b = tbv; sub = ts; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0;
        cin_seq = 8'h00;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) break;
            if (i < 8) cin_seq[i] = cell_cin;
            @(negedge clk);
            lat++;
        end
    endtask

    // Reference for the streaming test: {zero, overflow, carry, y}.
    function automatic logic [10:0] ref_op(input logic [7:0] x, input logic [7:0] yv, input logic s);
        logic [7:0] bb;
        logic [8:0] sum;
        logic       v;
        bb  = s ? ~yv : yv;
        sum = {1'b0, x} + {1'b0, bb} + {8'h00, s};
        v   = (x[7] == bb[7]) && (sum[7] != x[7]);
        return {(sum[7:0] == 8'h00), v, sum[8], sum[7:0]};
    endfunction

    initial begin
        logic [7:0] hold_y;
        logic [10:0] exp_r;
        logic [7:0] qa[$];
        logic [7:0] qb[$];
        logic       qs[$];
        int         acc_cyc[$];
        int         n_res;
        int         both_hi;
        logic       prev_rv;
        logic       rv_seen;

        rst_n = 1'b1; start_valid = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0; res_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_result("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check_eq("reset_rv", 32'(res_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("reset_sr", 32'(start_ready), 32'd1);

        // Basic add with latency and carry-chain trace.
        launch(8'h0F, 8'h01, 1'b0);
        check_eq("add0_lat", 32'(lat), 32'd8);
        check_eq("add0_cin", 32'(cin_seq), 32'h1E);
        check_result("add0", 8'h10, 1'b0, 1'b0, 1'b0);
        check_eq("add0_sr_in_done", 32'(start_ready), 32'd0);
        @(negedge clk);
        check_eq("add0_rv_after", 32'(res_valid), 32'd0);
        check_eq("add0_sr_after", 32'(start_ready), 32'd1);

        launch(8'hFF, 8'h01, 1'b0);
        check_result("add_wrap", 8'h00, 1'b1, 1'b0, 1'b1);
        launch(8'h7F, 8'h01, 1'b0);
        check_result("add_ovf", 8'h80, 1'b0, 1'b1, 1'b0);
        launch(8'h05, 8'h07, 1'b1);
        check_result("sub_neg", 8'hFE, 1'b0, 1'b0, 1'b0);
        launch(8'h80, 8'h01, 1'b1);
        check_result("sub_ovf", 8'h7F, 1'b1, 1'b1, 1'b0);
        launch(8'h33, 8'h33, 1'b1);
        check_result("sub_zero", 8'h00, 1'b1, 1'b0, 1'b1);
        check_eq("sub_lat", 32'(lat), 32'd8);

        // Back-pressure: DONE held with operands toggling and start asserted.
        @(negedge clk);
        res_ready = 1'b0;
        launch(8'h12, 8'h34, 1'b0);
        check_eq("bp_lat", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1; a = 8'hFF; b = 8'hFF; sub = 1'b1;
            @(negedge clk);
            check_result("bp_hold", 8'h46, 1'b0, 1'b0, 1'b0);
            check_eq("bp_rv", 32'(res_valid), 32'd1);
            check_eq("bp_sr", 32'(start_ready), 32'd0);
        end
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_rv_drop", 32'(res_valid), 32'd0);
        check_eq("bp_sr_rise", 32'(start_ready), 32'd1);
        check_result("bp_keep", 8'h46, 1'b0, 1'b0, 1'b0);

        // Streaming: start held high, operands change every cycle.
        n_res = 0; both_hi = 0; prev_rv = 1'b0;
        for (int cyc = 0; cyc < 52; cyc++) begin
            if (res_valid && !prev_rv) begin
                if (qa.size() > 0) begin
                    exp_r = ref_op(qa.pop_front(), qb.pop_front(), qs.pop_front());
                    check_result("stream", exp_r[7:0], exp_r[8], exp_r[9], exp_r[10]);
                end
                n_res++;
            end
            if (res_valid && start_ready) both_hi++;
            prev_rv = res_valid;
            start_valid = (cyc < 45);
            a   = 8'(cyc * 37 + 5);
            b   = 8'(cyc * 91 + 3);
            sub = 1'((cyc / 10) % 2);
            if (start_ready && start_valid) begin
                qa.push_back(a); qb.push_back(b); qs.push_back(sub);
                acc_cyc.push_back(cyc);
            end
            @(negedge clk);
        end
        start_valid = 1'b0;
        check_eq("stream_nres", 32'(n_res), 32'd5);
        check_eq("stream_nacc", 32'(acc_cyc.size()), 32'd5);
        check_eq("stream_both_hi", 32'(both_hi), 32'd0);
        for (int i = 1; i < acc_cyc.size(); i++) begin
            check_eq("stream_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd10);
        end

        // Asynchronous reset in the middle of RUN.
        @(negedge clk);
        a = 8'h5A; b = 8'h11; sub = 1'b0; start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_result("rst_mid", 8'h00, 1'b0, 1'b0, 1'b0);
        check_eq("rst_mid_rv", 32'(res_valid), 32'd0);
        check_eq("rst_mid_cell", 32'({cell_a, cell_b, cell_cin}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_rel_sr", 32'(start_ready), 32'd1);
        rv_seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (res_valid) rv_seen = 1'b1;
        end
        check_eq("rst_no_rv", 32'(rv_seen), 32'd0);
        launch(8'h01, 8'h01, 1'b0);
        check_result("rst_after", 8'h02, 1'b0, 1'b0, 1'b0);
        check_eq("rst_after_lat", 32'(lat), 32'd8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_add_sequencer.md
# serial_add_sequencer

Bit-serial add/subtract sequencer that drives the 1-bit full-adder cell of the ALU datapath and consumes its outputs. It accepts two WIDTH-bit operands over a valid/ready handshake. It then feeds the cell one bit pair per clock, LSB first, keeping the running carry in a flop, and assembles the WIDTH-bit result with Carry, Overflow and Zero flags. The result is presented downstream over a second valid/ready handshake.

## Interface
- WIDTH, 8: operand/result width in bits; legal range is 2 or more.
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  reset, asynchronous, active-low.
- Start_valid  input  1  operands and Sub are valid.
- Start_ready  output  1  sequencer can accept operands.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Sub  input  1  0 computes A+B; 1 computes A-B.
- Cell_A  output  1  A bit to the full-adder cell.
- Cell_B  output  1  B bit to the cell; already inverted when subtracting.
- Cell_Cin  output  1  carry-in to the cell.
- Cell_Y  input  1  sum bit returned by the cell.
- Cell_Carry  input  1  carry-out returned by the cell.
- Y  output  WIDTH  result.
- Carry  output  1  final carry-out. For Sub=1 this is the no-borrow flag: 1 when A≥B unsigned.
- Overflow  output  1  two's-complement overflow.
- Zero  output  1  Y == 0.
- Res_valid  output  1  Y and flags are valid.
- Res_ready  input  1  consumer accepts the result.

## Operation
- The state machine has three states: IDLE, RUN and DONE.
- **Reset** (Rst_n=0, immediate, from any state):
  - state=IDLE, bit counter=0, carry flop=0.
  - Y=0, Carry=0, Overflow=0, Zero=0, Res_valid=0.
  - Start_ready=1 once Rst_n is released.
- **IDLE:**
  - Start_ready=1. Cell_A, Cell_B and Cell_Cin are driven 0.
  - On an edge with Start_valid=1:
    - load the A shift register with A;
    - load the B shift register with B XOR {WIDTH{Sub}};
    - set the carry flop to Sub and the counter to 0;
    - go to RUN.
- **RUN:**
  - Start_ready=0, Res_valid=0.
  - The cell inputs are combinational from registered state: Cell_A=a_sh[0], Cell_B=b_sh[0], Cell_Cin=carry_q.
  - On each edge:
    - shift Cell_Y into the result register at the MSB end, shifting right;
    - set carry_q to Cell_Carry;
    - shift a_sh and b_sh right by one;
    - increment the counter.
  - On the edge where the counter equals WIDTH-2, capture cin_msb = Cell_Carry. This is the carry into the MSB.
  - On the edge where the counter equals WIDTH-1, go to DONE and register the result and flags:
    - Y = assembled result;
    - Carry = Cell_Carry;
    - Overflow = cin_msb XOR Cell_Carry;
    - Zero = (assembled Y == 0).
- **DONE:**
  - Res_valid=1. Y and the flags are held stable.
  - Operand inputs are ignored.
  - On an edge with Res_ready=1, go to IDLE. Res_valid drops, and Y and the flags keep their last values.
- **Arithmetic width:**
  - Carry is the carry out of bit WIDTH-1. There is no wider internal sum.
  - The counter width is clog2(WIDTH).
- The cell is treated as purely combinational; a cell with a zero-cycle path is required.

## Timing
- **Acceptance:** the handshake completes on the edge where Start_valid and Start_ready are both 1 (edge 0).
- **Latency:**
  - RUN occupies edges 1..WIDTH.
  - Res_valid rises after edge WIDTH, i.e. WIDTH cycles after acceptance. For WIDTH=8, Res_valid is high in cycle 8 after edge 0.
- **Throughput:**
  - The minimum period between acceptances is WIDTH+2 cycles: RUN, at least one DONE cycle, and one IDLE cycle.
  - Start_ready is never asserted in the same cycle as Res_valid.
- **Back-pressure:** with Res_ready=0, DONE persists indefinitely with outputs frozen.
- **Start held in RUN/DONE:** Start_valid=1 has no effect. It is accepted only in the next IDLE cycle.
- **Reset mid-operation:** the operation is aborted with no result emitted. The first cycle after reset release is IDLE.
- **Flops:** all flops are asynchronously cleared. There is no synchronous clear.

## Test plan
- A=0x0F, B=0x01, Sub=0 → Y=0x10, Carry=0, Overflow=0, Zero=0. Res_valid rises exactly 8 cycles after acceptance. Cell_Cin sequence is 0,1,1,1,1,0,0,0.
- A=0xFF, B=0x01, Sub=0 → Y=0x00, Carry=1, Overflow=0, Zero=1. Also A=0x7F, B=0x01 → Y=0x80, Overflow=1, Carry=0.
- Subtract cases:
  - A=0x05, B=0x07, Sub=1 → Y=0xFE, Carry=0, Overflow=0, Zero=0.
  - A=0x80, B=0x01, Sub=1 → Y=0x7F, Carry=1, Overflow=1.
  - A=0x33, B=0x33, Sub=1 → Y=0x00, Zero=1, Carry=1.
- Back-pressure: hold Res_ready=0 for 5 cycles after Res_valid → Y and the flags are stable and Start_ready=0 throughout. Raise Res_ready → Res_valid=0 and Start_ready=1 on the next cycle.
- Keep Start_valid=1 continuously with changing operands → each result matches the operands sampled at the acceptance edge. Acceptances are spaced exactly 10 cycles apart with Res_ready=1.
- Assert Rst_n=0 asynchronously at RUN bit 4 → all outputs read 0 and Start_ready=1 after release with no Res_valid pulse. A following 0x01+0x01 yields Y=0x02.
